// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline controller for the 5-stage integer datapath.
// Detects data hazards between ID sources and EX/MEM destinations, flushes on
// taken branches, freezes the front end while the multi-cycle multiplier runs,
// and keeps a saturating count of cycles in which the PC was held.
//
// Optional feature macro: HAZARD_FORWARDING_EN
//   defined   -> operand forwarding enabled; only load-use stalls one cycle.
//   undefined -> no forwarding; any pending EX/MEM writer of a used source stalls.
module hazard_stall_ctrl #(
  parameter int MUL_CYCLES = 4,   // legal range 1..15
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_mul,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_hold,
  output logic             mul_start,
  output logic             mul_busy,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {RUN, MUL_WAIT} state_t;

  // MUL_WAIT lasts cnt+1 cycles, so loading MUL_CYCLES-1 gives exactly MUL_CYCLES.
  localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       hazard;

  // True when a used, nonzero source register is about to be written by dst.
  function automatic logic src_hit(input logic [4:0] src, input logic used,
                                   input logic [4:0] dst, input logic wr);
    return used && wr && (src != 5'd0) && (src == dst);
  endfunction

`ifdef HAZARD_FORWARDING_EN
  // Forward select for one operand: the youngest producer (EX/MEM) wins.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (ex_reg_write && src != 5'd0 && src == ex_rd)
      return 2'd1;
    else if (mem_reg_write && src != 5'd0 && src == mem_rd)
      return 2'd2;
    else
      return 2'd0;
  endfunction

  // Only a load in EX cannot be forwarded in time: one-cycle load-use stall.
  always_comb begin
    hazard = ex_mem_read &&
             (src_hit(id_rs, id_uses_rs, ex_rd, 1'b1) ||
              src_hit(id_rt, id_uses_rt, ex_rd, 1'b1));
  end
`else
  logic unused_mem_read;
  assign unused_mem_read = ex_mem_read;

  // Without forwarding, any in-flight writer of a used source must drain first.
  always_comb begin
    hazard = src_hit(id_rs, id_uses_rs, ex_rd,  ex_reg_write)  ||
             src_hit(id_rt, id_uses_rt, ex_rd,  ex_reg_write)  ||
             src_hit(id_rs, id_uses_rs, mem_rd, mem_reg_write) ||
             src_hit(id_rt, id_uses_rt, mem_rd, mem_reg_write);
  end
`endif

  // Pipeline controls decoded from state and current inputs (same-cycle effect).
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    id_ex_hold   = 1'b0;
    mul_start    = 1'b0;
    mul_busy     = 1'b0;
    fwd_a        = 2'd0;
    fwd_b        = 2'd0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
`ifdef HAZARD_FORWARDING_EN
      fwd_a = fwd_sel(id_rs);
      fwd_b = fwd_sel(id_rt);
`endif
      if (state == MUL_WAIT) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_hold  = 1'b1;
        mul_busy    = 1'b1;
      end else if (branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (hazard) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end else begin
        mul_start = id_is_mul;
      end
    end
  end

  // Multiply sequencing state and the saturating stall counter.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state       <= RUN;
      cnt         <= 4'd0;
      stall_count <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mul_start) begin
            state <= MUL_WAIT;
            cnt   <= CNT_LOAD;
          end
        end
        MUL_WAIT: begin
          if (cnt == 4'd0) state <= RUN;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= RUN;
      endcase
      if (!pc_write && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios followed by a
// randomized run, every cycle compared against a behavioural model.
module tb_hazard_stall_ctrl;

  localparam int MUL_CYCLES = 4;
  localparam int CNT_W      = 4;
  localparam int STALL_MAX  = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_rd, mem_rd;
  logic             id_uses_rs, id_uses_rt, id_is_mul;
  logic             ex_reg_write, ex_mem_read, mem_reg_write, branch_taken;
  logic             pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold;
  logic             mul_start, mul_busy;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model state: cycles of multiply still to run, and stall cycles so far.
  int m_mul_left = 0;
  int m_stall    = 0;

  typedef struct packed {
    logic       pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic       id_ex_hold, mul_start, mul_busy;
    logic [1:0] fwd_a, fwd_b;
  } exp_t;

  hazard_stall_ctrl #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_mul(id_is_mul), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .branch_taken(branch_taken), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .id_ex_hold(id_ex_hold),
    .mul_start(mul_start), .mul_busy(mul_busy), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Does the instruction in a stage (dst, writes) produce a source ID reads?
  function automatic bit produces(input logic [4:0] src, input logic used,
                                  input logic [4:0] dst, input logic writes);
    return used && writes && src != 0 && src == dst;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
`ifdef HAZARD_FORWARDING_EN
    if (produces(src, 1'b1, ex_rd, ex_reg_write))   return 2'd1;
    if (produces(src, 1'b1, mem_rd, mem_reg_write)) return 2'd2;
`endif
    return 2'd0;
  endfunction

  function automatic bit model_hazard();
`ifdef HAZARD_FORWARDING_EN
    return ex_mem_read && (produces(id_rs, id_uses_rs, ex_rd, 1'b1) ||
                           produces(id_rt, id_uses_rt, ex_rd, 1'b1));
`else
    return produces(id_rs, id_uses_rs, ex_rd, ex_reg_write)   ||
           produces(id_rt, id_uses_rt, ex_rd, ex_reg_write)   ||
           produces(id_rs, id_uses_rs, mem_rd, mem_reg_write) ||
           produces(id_rt, id_uses_rt, mem_rd, mem_reg_write);
`endif
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    if (reset) begin
      e.if_id_flush  = 1'b1;
      e.id_ex_bubble = 1'b1;
      return e;
    end
    e.fwd_a = model_fwd(id_rs);
    e.fwd_b = model_fwd(id_rt);
    if (m_mul_left > 0) begin
      e.id_ex_hold = 1'b1;
      e.mul_busy   = 1'b1;
    end else if (branch_taken) begin
      e.pc_write = 1'b1; e.if_id_write = 1'b1;
      e.if_id_flush = 1'b1; e.id_ex_bubble = 1'b1;
    end else if (model_hazard()) begin
      e.id_ex_bubble = 1'b1;
    end else begin
      e.pc_write = 1'b1; e.if_id_write = 1'b1;
      e.mul_start = id_is_mul;
    end
    return e;
  endfunction

  // Compare one cycle against the model, then advance model and clock.
  task automatic tick(input string tag);
    exp_t e;
    #2;
    e = model_out();
    check({tag, ".pc_write"},     32'(pc_write),     32'(e.pc_write));
    check({tag, ".if_id_write"},  32'(if_id_write),  32'(e.if_id_write));
    check({tag, ".if_id_flush"},  32'(if_id_flush),  32'(e.if_id_flush));
    check({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(e.id_ex_bubble));
    check({tag, ".id_ex_hold"},   32'(id_ex_hold),   32'(e.id_ex_hold));
    check({tag, ".mul_start"},    32'(mul_start),    32'(e.mul_start));
    check({tag, ".mul_busy"},     32'(mul_busy),     32'(e.mul_busy));
    check({tag, ".fwd_a"},        32'(fwd_a),        32'(e.fwd_a));
    check({tag, ".fwd_b"},        32'(fwd_b),        32'(e.fwd_b));
    check({tag, ".stall_count"},  32'(stall_count),  32'(m_stall));
    @(posedge clock);
    cyc++;
    if (reset) begin
      m_mul_left = 0;
      m_stall    = 0;
    end else begin
      if (!e.pc_write && m_stall < STALL_MAX) m_stall++;
      if (m_mul_left > 0)   m_mul_left--;
      else if (e.mul_start) m_mul_left = MUL_CYCLES;
    end
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_is_mul = 0; ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_rd = 0; mem_reg_write = 0; branch_taken = 0;
  endtask

  initial begin
    int busy_cycles;
    idle();
    reset = 1'b1;
    @(posedge clock); #1;

    // 1. Reset held three cycles, then released with no hazards.
    for (int i = 0; i < 3; i++) tick("t1_reset");
    reset = 1'b0;
    #2;
    check("t1_pc_write_after", 32'(pc_write), 32'd1);
    check("t1_if_id_write_after", 32'(if_id_write), 32'd1);
    check("t1_count_after", 32'(stall_count), 32'd0);
    tick("t1_run");

`ifdef HAZARD_FORWARDING_EN
    // 2. Load-use stalls one cycle; non-load producer forwards instead.
    id_rs = 5; id_uses_rs = 1; ex_rd = 5; ex_reg_write = 1; ex_mem_read = 1;
    tick("t2_loaduse");
    ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; mem_rd = 5; mem_reg_write = 1;
    tick("t2_after_bubble");
    mem_reg_write = 0; ex_rd = 5; ex_reg_write = 1;
    #2;
    check("t2_fwd_ex", 32'(fwd_a), 32'd1);
    check("t2_no_stall", 32'(pc_write), 32'd1);
    tick("t2_fwd");
    ex_rd = 0;
    tick("t2_r0");
    idle();
`else
    // 3. Writer of rt advancing EX -> MEM stalls two cycles.
    id_rt = 7; id_uses_rt = 1; ex_rd = 7; ex_reg_write = 1;
    tick("t3_ex");
    ex_rd = 0; ex_reg_write = 0; mem_rd = 7; mem_reg_write = 1;
    tick("t3_mem");
    mem_rd = 0; mem_reg_write = 0;
    tick("t3_clear");
    check("t3_count", 32'(stall_count), 32'd2);
    idle();
`endif

    // 4. Multiply: one start pulse, four busy cycles, branch ignored meanwhile.
    id_is_mul = 1;
    #2;
    check("t4_start", 32'(mul_start), 32'd1);
    tick("t4_issue");
    id_is_mul = 0;
    busy_cycles = 0;
    for (int i = 0; i < MUL_CYCLES + 1; i++) begin
      branch_taken = (i == 1);
      #2;
      if (mul_busy === 1'b1) busy_cycles++;
      if (i == 1) check("t4_no_flush", 32'(if_id_flush), 32'd0);
      tick("t4_wait");
    end
    check("t4_busy_len", 32'(busy_cycles), 32'(MUL_CYCLES));
    idle();

    // 5. Branch outranks a simultaneous load-use hazard.
    branch_taken = 1; id_rs = 3; id_uses_rs = 1;
    ex_rd = 3; ex_reg_write = 1; ex_mem_read = 1;
    #2;
    check("t5_flush", 32'(if_id_flush), 32'd1);
    check("t5_pc_write", 32'(pc_write), 32'd1);
    tick("t5_branch");
    idle();

    // 6. Reset in second MUL_WAIT cycle, then counter saturation.
    id_is_mul = 1;
    tick("t6_issue");
    id_is_mul = 0;
    tick("t6_wait1");
    reset = 1;
    tick("t6_reset");
    reset = 0;
    #2;
    check("t6_busy_after_reset", 32'(mul_busy), 32'd0);
    id_rs = 1; id_uses_rs = 1; ex_rd = 1; ex_reg_write = 1; ex_mem_read = 1;
    for (int i = 0; i < STALL_MAX - 1; i++) tick("t6_fill");
    check("t6_near_max", 32'(stall_count), 32'(STALL_MAX - 1));
    for (int i = 0; i < 3; i++) tick("t6_sat");
    check("t6_saturated", 32'(stall_count), 32'(STALL_MAX));
    idle();

    // Randomized traffic over a small register range to provoke matches.
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(0, 39) == 0);
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      id_uses_rs    = 1'($urandom);
      id_uses_rt    = 1'($urandom);
      id_is_mul     = ($urandom_range(0, 6) == 0);
      ex_rd         = 5'($urandom_range(0, 3));
      ex_reg_write  = 1'($urandom);
      ex_mem_read   = 1'($urandom);
      mem_rd        = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom);
      branch_taken  = ($urandom_range(0, 9) == 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
